// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared encodings for the data-memory responder:
//                funct3 access sizes, FSM states and the byte-enable type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Load/store access size encodings (U forms are load-only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [3:0] be_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering. Produces store byte
//                enables and replicated store data, extracts and extends the
//                load result, and flags misaligned or illegal accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output be_t         o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane selection out of the stored word
  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Decode size: replicate store data across all lanes so the enables alone pick the target
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = 32'h0;
    o_err   = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = be_t'(4'b0001 << i_addr_lo);
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: begin
        o_err   = i_write;
        o_rdata = {24'h0, w_byte};
      end
      F3_H: begin
        o_err   = i_addr_lo[0];
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F3_HU: begin
        o_err   = i_write | i_addr_lo[0];
        o_rdata = {16'h0, w_half};
      end
      F3_W: begin
        o_err   = |i_addr_lo;
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for the CPU load/store port. Accepts
//                one request, waits WAIT_STATES cycles, then performs the
//                array access and returns a one-cycle response.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          c_IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  c_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_write;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic [2:0]   r_funct3;
  logic [31:0]  r_mem [DEPTH_WORDS];

  logic         w_src_live;
  logic         w_s_write;
  logic [31:0]  w_s_addr;
  logic [31:0]  w_s_wdata;
  logic [2:0]   w_s_funct3;
  logic [31:0]  w_off;
  logic         w_oor;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]  w_rword;
  be_t          w_be;
  logic [31:0]  w_wdata_sh;
  logic [31:0]  w_rdata_ext;
  logic         w_align_err;
  logic         w_err;
  logic         w_enter_resp;
  logic         w_commit;

  // With no wait states the access happens on the accept edge, so the live
  // request fields are used; otherwise the captured copy is used.
  assign w_src_live = (r_state == IDLE);
  assign w_s_write  = w_src_live ? req_write  : r_write;
  assign w_s_addr   = w_src_live ? req_addr   : r_addr;
  assign w_s_wdata  = w_src_live ? req_wdata  : r_wdata;
  assign w_s_funct3 = w_src_live ? req_funct3 : r_funct3;

  // Offset below BASE_ADDR wraps to a large value and is caught by the same compare
  assign w_off   = w_s_addr - BASE_ADDR;
  assign w_oor   = ({1'b0, w_off} >= c_SPAN);
  assign w_idx   = w_off[c_IDX_W+1:2];
  assign w_rword = r_mem[w_idx];

  mem_lane_align u_align (
    .i_write   (w_s_write),
    .i_funct3  (w_s_funct3),
    .i_addr_lo (w_s_addr[1:0]),
    .i_wdata   (w_s_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_rdata_ext),
    .o_err     (w_align_err)
  );

  assign w_err        = w_align_err | w_oor;
  assign w_enter_resp = ((r_state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                        ((r_state == WAIT) && (r_cnt == c_WAIT_LAST));
  assign w_commit     = w_enter_resp && w_s_write && !w_err;

  // Request FSM with wait counter, capture registers and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_funct3  <= 3'b000;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_funct3  <= req_funct3;
            r_cnt     <= 4'd0;
            req_ready <= 1'b0;
            r_state   <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == c_WAIT_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (w_enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= w_err;
        rsp_rdata <= (w_err || w_s_write) ? 32'h0 : w_rdata_ext;
      end
    end
  end

  // Storage array: only enabled byte lanes of a legal store are written
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. Two instances:
//                A (1024 words, 2 wait states, base 0) and
//                B (64 words, 0 wait states, base 0x1000).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int unsigned A_DEPTH = 1024;
  localparam int unsigned A_WAIT  = 2;
  localparam logic [31:0] A_BASE  = 32'h0;
  localparam int unsigned B_DEPTH = 64;
  localparam int unsigned B_WAIT  = 0;
  localparam logic [31:0] B_BASE  = 32'h1000;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [2:0]  a_req_funct3 = '0;
  logic        a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [2:0]  b_req_funct3 = '0;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  // Reference memory images: one byte per entry, plus a written-yet flag
  logic [7:0] mem_a [4*A_DEPTH];
  bit         kn_a  [4*A_DEPTH];
  logic [7:0] mem_b [4*B_DEPTH];
  bit         kn_b  [4*B_DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(A_DEPTH), .WAIT_STATES(A_WAIT), .BASE_ADDR(A_BASE)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_funct3(a_req_funct3),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(B_DEPTH), .WAIT_STATES(B_WAIT), .BASE_ADDR(B_BASE)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_funct3(b_req_funct3),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_req_ready : a_req_ready;
  endfunction

  function automatic logic rvld(input bit b);
    return b ? b_rsp_valid : a_rsp_valid;
  endfunction

  task automatic drive(input bit b, input logic v, input logic w, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (b) begin
      b_req_valid = v; b_req_write = w; b_req_addr = addr; b_req_wdata = wd; b_req_funct3 = f3;
    end else begin
      a_req_valid = v; a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_funct3 = f3;
    end
  endtask

  // Reference: size from funct3, legality, range and alignment from plain arithmetic
  task automatic model(input bit b, input bit w, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output bit err, output bit unk);
    int unsigned span, off, nb;
    logic [31:0] v;
    span = b ? 4*B_DEPTH : 4*A_DEPTH;
    off  = addr - (b ? B_BASE : A_BASE);
    nb   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    rd = 32'h0; err = 1'b0; unk = 1'b0;
    if (!(f3 inside {F_B, F_H, F_W, F_BU, F_HU}) || (w && f3[2])) err = 1'b1;
    if (off >= span) err = 1'b1;
    if ((addr % nb) != 0) err = 1'b1;
    if (err) return;
    if (w) begin
      for (int k = 0; k < 4; k++) begin
        if (k < nb) begin
          if (b) begin mem_b[off+k] = wd[8*k +: 8]; kn_b[off+k] = 1'b1; end
          else   begin mem_a[off+k] = wd[8*k +: 8]; kn_a[off+k] = 1'b1; end
        end
      end
    end else begin
      v = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (k < nb) begin
          v[8*k +: 8] = b ? mem_b[off+k] : mem_a[off+k];
          if (!(b ? kn_b[off+k] : kn_a[off+k])) unk = 1'b1;
        end
      end
      if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end
  endtask

  // One complete handshake, also checking latency, busy window and pulse width
  task automatic txn(input bit b, input logic w, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, output logic [31:0] rd, output logic e);
    int n;
    bit busy_ok;
    n = 0;
    @(negedge clk);
    while (!rdy(b) && n < 40) begin @(negedge clk); n++; end
    drive(b, 1'b1, w, addr, wd, f3);
    @(posedge clk);
    @(negedge clk);
    drive(b, 1'b0, 1'($urandom), $urandom, $urandom, 3'($urandom));
    n = 1; busy_ok = 1'b1;
    while (!rvld(b) && n < 40) begin
      if (rdy(b)) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (rdy(b)) busy_ok = 1'b0;
    rd = b ? b_rsp_rdata : a_rsp_rdata;
    e  = b ? b_rsp_err   : a_rsp_err;
    chk(b ? "B_latency" : "A_latency", 32'(n), 32'(b ? B_WAIT + 1 : A_WAIT + 1));
    chk("ready_low_while_busy", {31'h0, busy_ok}, 32'd1);
    @(negedge clk);
    chk("rsp_single_pulse", {31'h0, rvld(b)}, 32'd0);
    chk("ready_back", {31'h0, rdy(b)}, 32'd1);
  endtask

  task automatic run_vs_model(input string tag, input bit b, input bit w, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] rd, mrd;
    logic e;
    bit merr, munk;
    model(b, w, addr, wd, f3, mrd, merr, munk);
    txn(b, w, addr, wd, f3, rd, e);
    chk($sformatf("%s_err a=%h f3=%0d w=%0d", tag, addr, f3, w), {31'h0, e}, {31'h0, merr});
    if (!munk) chk($sformatf("%s_rdata a=%h f3=%0d w=%0d", tag, addr, f3, w), rd, mrd);
  endtask

  typedef struct {
    bit          b;
    bit          w;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  localparam int NV = 30;
  vec_t tv [NV];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd, mrd;
    logic e;
    bit merr, munk;

    tv[0]  = '{0, 1, 32'h10,       32'h12345678, F_W,   32'h0,        0};
    tv[1]  = '{0, 1, 32'h20,       32'h11223344, F_W,   32'h0,        0};
    tv[2]  = '{0, 0, 32'h23,       32'h0,        F_B,   32'h00000011, 0};
    tv[3]  = '{0, 0, 32'h22,       32'h0,        F_H,   32'h00001122, 0};
    tv[4]  = '{0, 0, 32'h20,       32'h0,        F_BU,  32'h00000044, 0};
    tv[5]  = '{0, 1, 32'h40,       32'h0,        F_W,   32'h0,        0};
    tv[6]  = '{0, 1, 32'h41,       32'h80,       F_B,   32'h0,        0};
    tv[7]  = '{0, 0, 32'h40,       32'h0,        F_W,   32'h00008000, 0};
    tv[8]  = '{0, 0, 32'h41,       32'h0,        F_B,   32'hFFFFFF80, 0};
    tv[9]  = '{0, 0, 32'h41,       32'h0,        F_BU,  32'h00000080, 0};
    tv[10] = '{0, 0, 32'h22,       32'h0,        F_W,   32'h0,        1};
    tv[11] = '{0, 1, 32'h21,       32'hBEEF,     F_H,   32'h0,        1};
    tv[12] = '{0, 0, 32'h20,       32'h0,        3'b011, 32'h0,       1};
    tv[13] = '{0, 1, 32'h20,       32'h55,       F_BU,  32'h0,        1};
    tv[14] = '{0, 0, 32'h20,       32'h0,        F_W,   32'h11223344, 0};
    tv[15] = '{0, 0, 32'h1000,     32'h0,        F_W,   32'h0,        1};
    tv[16] = '{0, 0, 32'hFFFFFFFC, 32'h0,        F_W,   32'h0,        1};
    tv[17] = '{0, 1, 32'hFFC,      32'hAABBCCDD, F_W,   32'h0,        0};
    tv[18] = '{0, 0, 32'hFFC,      32'h0,        F_W,   32'hAABBCCDD, 0};
    tv[19] = '{0, 0, 32'hFFE,      32'h0,        F_HU,  32'h0000AABB, 0};
    tv[20] = '{0, 0, 32'hFFE,      32'h0,        F_H,   32'hFFFFAABB, 0};
    tv[21] = '{1, 1, 32'h1000,     32'hCAFEF00D, F_W,   32'h0,        0};
    tv[22] = '{1, 0, 32'h1000,     32'h0,        F_W,   32'hCAFEF00D, 0};
    tv[23] = '{1, 0, 32'h0FFC,     32'h0,        F_W,   32'h0,        1};
    tv[24] = '{1, 0, 32'h1100,     32'h0,        F_W,   32'h0,        1};
    tv[25] = '{1, 1, 32'h10FE,     32'h8001,     F_H,   32'h0,        0};
    tv[26] = '{1, 0, 32'h10FE,     32'h0,        F_H,   32'hFFFF8001, 0};
    tv[27] = '{1, 0, 32'h10FF,     32'h0,        F_BU,  32'h00000080, 0};
    tv[28] = '{1, 0, 32'h1002,     32'h0,        F_HU,  32'h0000CAFE, 0};
    tv[29] = '{1, 0, 32'h1000,     32'h0,        3'b110, 32'h0,       1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("A_reset_ready", {31'h0, a_req_ready}, 32'd1);
    chk("A_reset_rsp_valid", {31'h0, a_rsp_valid}, 32'd0);
    chk("A_reset_rdata", a_rsp_rdata, 32'h0);
    chk("A_reset_err", {31'h0, a_rsp_err}, 32'd0);
    chk("B_reset_ready", {31'h0, b_req_ready}, 32'd1);
    chk("B_reset_rsp_valid", {31'h0, b_rsp_valid}, 32'd0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      model(tv[i].b, tv[i].w, tv[i].addr, tv[i].wd, tv[i].f3, mrd, merr, munk);
      txn(tv[i].b, tv[i].w, tv[i].addr, tv[i].wd, tv[i].f3, rd, e);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, tv[i].err});
    end

    // Reset in the middle of a store's wait period: store must be dropped
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, F_W);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, F_B);
    rst = 1'b0;
    #1;
    chk("midreset_ready", {31'h0, a_req_ready}, 32'd1);
    chk("midreset_rsp_valid", {31'h0, a_rsp_valid}, 32'd0);
    chk("midreset_rdata", a_rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    txn(0, 1'b0, 32'h10, 32'h0, F_W, rd, e);
    chk("after_reset_LW_0x10", rd, 32'h12345678);
    chk("after_reset_LW_0x10_err", {31'h0, e}, 32'd0);

    // Fill the random window with known contents
    for (int k = 0; k < 16; k++) begin
      run_vs_model("initA", 0, 1'b1, A_BASE + 32'(4*k), $urandom, F_W);
      run_vs_model("initB", 1, 1'b1, B_BASE + 32'(4*k), $urandom, F_W);
    end
    for (int k = 1; k <= 2; k++) begin
      run_vs_model("initA", 0, 1'b1, A_BASE + 32'(4*A_DEPTH - 4*k), $urandom, F_W);
      run_vs_model("initB", 1, 1'b1, B_BASE + 32'(4*B_DEPTH - 4*k), $urandom, F_W);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 250; i++) begin
      bit          b;
      int unsigned r, span;
      logic [31:0] off;
      b    = 1'($urandom);
      span = b ? 4*B_DEPTH : 4*A_DEPTH;
      r    = $urandom_range(0, 9);
      if (r < 7)      off = 32'($urandom_range(0, 63));
      else if (r < 9) off = 32'(span - 8 + $urandom_range(0, 11));
      else            off = $urandom;
      run_vs_model("rand", b, 1'($urandom), (b ? B_BASE : A_BASE) + off, $urandom,
                   3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_mem_responder
`default_nettype wire
